sd_init_sequencer: RTL and testbench

Host-side FSM that runs the SD card identification sequence through the CMD path: CMD0, CMD8, the CMD55/ACMD41 loop, CMD2 and CMD3. It sits above cmd_controller and drives its new_command, cmd_index and cmd_argument inputs. It consumes a per-command completion pulse carrying the 32-bit response and a timeout flag. It reports the card RCA, capacity class and pass/fail to the register block.

---
 rtl/sd_init_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: host-side SD card identification sequencer.
// Steps the card through CMD0, CMD8, CMD55/ACMD41 (with retries), CMD2 and CMD3.
// It drives the command controller one command at a time and reports RCA,
// capacity class and the pass/fail result.
module sd_init_sequencer #(
    parameter int unsigned ACMD41_RETRIES = 1000,
    parameter int unsigned RETRY_GAP      = 1024,
    parameter int unsigned WAIT_LIMIT     = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ocr_arg,
    output logic        cmd_new,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    input  logic        cmd_done,
    input  logic [31:0] cmd_response,
    input  logic        cmd_timeout,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  error_code,
    output logic [15:0] rca,
    output logic        ccs,
    output logic        v2_card
);

    // One down-counter is shared by the response wait and the retry gap.
    localparam int unsigned CNT_MAX = (WAIT_LIMIT > RETRY_GAP) ? WAIT_LIMIT : RETRY_GAP;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int RTY_W = $clog2(ACMD41_RETRIES + 1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_CMD   = 3'd1;
    localparam logic [2:0] ERR_ECHO  = 3'd2;
    localparam logic [2:0] ERR_RETRY = 3'd3;
    localparam logic [2:0] ERR_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3
    } step_t;

    state_t             r_state, w_state_nxt;
    step_t              r_step, w_step_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [RTY_W-1:0]   r_retry, w_retry_nxt, w_retry_inc;
    logic [2:0]         r_error_code, w_err_nxt;
    logic [15:0]        r_rca, w_rca_nxt;
    logic               r_ccs, w_ccs_nxt;
    logic               r_v2, w_v2_nxt;
    logic [5:0]         r_cmd_index, w_idx_nxt;
    logic [31:0]        r_cmd_arg, w_arg_nxt;
    logic               w_unused_resp;

    // Response bits [15:12] carry nothing this sequencer acts on.
    assign w_unused_resp = ^cmd_response[15:12];

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_step       <= STEP_CMD0;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_error_code <= ERR_NONE;
            r_rca        <= '0;
            r_ccs        <= 1'b0;
            r_v2         <= 1'b0;
            r_cmd_index  <= '0;
            r_cmd_arg    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_error_code <= w_err_nxt;
            r_rca        <= w_rca_nxt;
            r_ccs        <= w_ccs_nxt;
            r_v2         <= w_v2_nxt;
            r_cmd_index  <= w_idx_nxt;
            r_cmd_arg    <= w_arg_nxt;
        end
    end

    // Next-state, step sequencing, counters and result latching.
    always_comb begin
        // NOTE: every target gets a hold default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_err_nxt   = r_error_code;
        w_rca_nxt   = r_rca;
        w_ccs_nxt   = r_ccs;
        w_v2_nxt    = r_v2;
        w_retry_inc = r_retry + RTY_W'(1);

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_step_nxt  = STEP_CMD0;
                    w_retry_nxt = '0;
                    w_err_nxt   = ERR_NONE;
                    w_rca_nxt   = '0;
                    w_ccs_nxt   = 1'b0;
                    w_v2_nxt    = 1'b0;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_W'(WAIT_LIMIT);
            end
            S_WAIT: begin
                if (cmd_done) begin
                    // Most outcomes issue the next command; failures override below.
                    w_state_nxt = S_ISSUE;
                    case (r_step)
                        STEP_CMD0: w_step_nxt = STEP_CMD8;
                        STEP_CMD8: begin
                            if (cmd_timeout) begin
                                w_v2_nxt   = 1'b0;
                                w_step_nxt = STEP_CMD55;
                            end else if (cmd_response[11:0] == 12'h1AA) begin
                                w_v2_nxt   = 1'b1;
                                w_step_nxt = STEP_CMD55;
                            end else begin
                                w_state_nxt = S_ERROR;
                                w_err_nxt   = ERR_ECHO;
                            end
                        end
                        STEP_CMD55: begin
                            if (cmd_timeout) begin
                                w_state_nxt = S_ERROR;
                                w_err_nxt   = ERR_CMD;
                            end else begin
                                w_step_nxt = STEP_ACMD41;
                            end
                        end
                        STEP_ACMD41: begin
                            if (!cmd_timeout && cmd_response[31]) begin
                                w_ccs_nxt  = cmd_response[30];
                                w_step_nxt = STEP_CMD2;
                            end else begin
                                w_retry_nxt = w_retry_inc;
                                if (w_retry_inc == RTY_W'(ACMD41_RETRIES)) begin
                                    w_state_nxt = S_ERROR;
                                    w_err_nxt   = ERR_RETRY;
                                end else begin
                                    w_state_nxt = S_GAP;
                                    w_cnt_nxt   = CNT_W'(RETRY_GAP);
                                end
                            end
                        end
                        STEP_CMD2: begin
                            if (cmd_timeout) begin
                                w_state_nxt = S_ERROR;
                                w_err_nxt   = ERR_CMD;
                            end else begin
                                w_step_nxt = STEP_CMD3;
                            end
                        end
                        STEP_CMD3: begin
                            if (cmd_timeout) begin
                                w_state_nxt = S_ERROR;
                                w_err_nxt   = ERR_CMD;
                            end else begin
                                w_rca_nxt   = cmd_response[31:16];
                                w_state_nxt = S_DONE;
                            end
                        end
                        default: begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = ERR_CMD;
                        end
                    endcase
                end else if (r_cnt <= CNT_W'(1)) begin
                    // Last allowed cycle passed without a completion.
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = ERR_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_ISSUE;
                    w_step_nxt  = STEP_CMD55;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Command fields are loaded on entry to ISSUE and held until the next issue.
        w_idx_nxt = r_cmd_index;
        w_arg_nxt = r_cmd_arg;
        if (w_state_nxt == S_ISSUE) begin
            case (w_step_nxt)
                STEP_CMD8: begin
                    w_idx_nxt = 6'd8;
                    w_arg_nxt = 32'h0000_01AA;
                end
                STEP_CMD55: begin
                    w_idx_nxt = 6'd55;
                    w_arg_nxt = {w_rca_nxt, 16'h0000};
                end
                STEP_ACMD41: begin
                    w_idx_nxt = 6'd41;
                    w_arg_nxt = ocr_arg;
                    if (!w_v2_nxt) w_arg_nxt[30] = 1'b0;
                end
                STEP_CMD2: begin
                    w_idx_nxt = 6'd2;
                    w_arg_nxt = '0;
                end
                STEP_CMD3: begin
                    w_idx_nxt = 6'd3;
                    w_arg_nxt = '0;
                end
                default: begin
                    w_idx_nxt = 6'd0;
                    w_arg_nxt = '0;
                end
            endcase
        end
    end

    assign cmd_new      = (r_state == S_ISSUE);
    assign cmd_index    = r_cmd_index;
    assign cmd_argument = r_cmd_arg;
    assign busy         = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_GAP);
    assign init_done    = (r_state == S_DONE);
    assign init_error   = (r_state == S_ERROR);
    assign error_code   = r_error_code;
    assign rca          = r_rca;
    assign ccs          = r_ccs;
    assign v2_card      = r_v2;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer: directed bench acting as the CMD path / card for sd_init_sequencer.
module tb_sd_init_sequencer;

    localparam int RETRIES = 3;
    localparam int GAP     = 8;
    localparam int WLIM    = 50;

    logic        clock = 1'b0;
    logic        reset, start, cmd_done, cmd_timeout;
    logic [31:0] ocr_arg, cmd_response;
    logic        cmd_new, busy, init_done, init_error, ccs, v2_card;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic [2:0]  error_code;
    logic [15:0] rca;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int n_new    = 0;
    int t_new, t_done, n_snap;
    logic [5:0] idx_log[$];

    sd_init_sequencer #(
        .ACMD41_RETRIES(RETRIES),
        .RETRY_GAP     (GAP),
        .WAIT_LIMIT    (WLIM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ocr_arg     (ocr_arg),
        .cmd_new     (cmd_new),
        .cmd_index   (cmd_index),
        .cmd_argument(cmd_argument),
        .cmd_done    (cmd_done),
        .cmd_response(cmd_response),
        .cmd_timeout (cmd_timeout),
        .busy        (busy),
        .init_done   (init_done),
        .init_error  (init_error),
        .error_code  (error_code),
        .rca         (rca),
        .ccs         (ccs),
        .v2_card     (v2_card)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Record every issued command index.
    always @(negedge clock) begin
        if (cmd_new) begin
            n_new++;
            idx_log.push_back(cmd_index);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for a cmd_new pulse and check the command it carries.
    task automatic wait_new(input string tag, input logic [5:0] idx, input logic [31:0] arg);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_new) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        t_new = cyc;
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_idx"}, 32'(cmd_index), 32'(idx));
            check({tag, "_arg"}, cmd_argument, arg);
        end
    endtask

    // One-cycle completion pulse, driven while the sequencer sits in WAIT.
    task automatic reply(input logic [31:0] resp, input logic to);
        @(negedge clock);
        cmd_done     = 1'b1;
        cmd_response = resp;
        cmd_timeout  = to;
        @(negedge clock);
        t_done       = cyc;
        cmd_done     = 1'b0;
        cmd_timeout  = 1'b0;
        cmd_response = '0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_new"}, 32'(cmd_new), 32'd0);
        check({tag, "_idx"}, 32'(cmd_index), 32'd0);
        check({tag, "_arg"}, cmd_argument, 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd0);
        check({tag, "_err"}, 32'(init_error), 32'd0);
        check({tag, "_code"}, 32'(error_code), 32'd0);
        check({tag, "_rca"}, 32'(rca), 32'd0);
        check({tag, "_ccs"}, 32'(ccs), 32'd0);
        check({tag, "_v2"}, 32'(v2_card), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_order [10];
        int         n41;
        bit         seen;
        exp_order = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3};

        reset = 1'b1; start = 1'b0; cmd_done = 1'b0; cmd_timeout = 1'b0;
        cmd_response = '0; ocr_arg = 32'h40FF_8000;
        repeat (3) @(negedge clock);
        check_cleared("rst0");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // SDv2 card: echo OK, two busy ACMD41 replies, then ready with CCS=1.
        idx_log.delete();
        pulse_start();
        check("v2_busy", 32'(busy), 32'd1);
        wait_new("v2_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("v2_c8", 6'd8, 32'h0000_01AA);
        check("v2_lat", 32'(t_new - t_done), 32'd0);
        reply(32'h0000_01AA, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_new("v2_c55", 6'd55, 32'h0);
            if (k > 0) check("v2_gap", 32'(t_new - t_done), 32'(GAP));
            reply(32'h0000_0120, 1'b0);
            wait_new("v2_a41", 6'd41, 32'h40FF_8000);
            reply((k == 2) ? 32'hC0FF_8000 : 32'h00FF_8000, 1'b0);
        end
        wait_new("v2_c2", 6'd2, 32'h0);
        reply(32'h1234_5678, 1'b0);
        wait_new("v2_c3", 6'd3, 32'h0);
        reply(32'hB368_0500, 1'b0);
        check("v2_done", 32'(init_done), 32'd1);
        check("v2_busy_end", 32'(busy), 32'd0);
        check("v2_err", 32'(init_error), 32'd0);
        check("v2_code", 32'(error_code), 32'd0);
        check("v2_rca", 32'(rca), 32'h0000_B368);
        check("v2_ccs", 32'(ccs), 32'd1);
        check("v2_v2", 32'(v2_card), 32'd1);
        repeat (3) @(negedge clock);
        check("v2_order_len", 32'(idx_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < idx_log.size(); i++)
            check($sformatf("v2_order%0d", i), 32'(idx_log[i]), 32'(exp_order[i]));

        // SDv1 card: CMD8 times out, HCS must be masked off the ACMD41 argument.
        pulse_start();
        check("v1_done_clr", 32'(init_done), 32'd0);
        check("v1_rca_clr", 32'(rca), 32'd0);
        wait_new("v1_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("v1_c8", 6'd8, 32'h0000_01AA);
        reply(32'h0, 1'b1);
        wait_new("v1_c55", 6'd55, 32'h0);
        reply(32'h0000_0120, 1'b0);
        wait_new("v1_a41", 6'd41, 32'h00FF_8000);
        reply(32'h80FF_8000, 1'b0);
        wait_new("v1_c2", 6'd2, 32'h0);
        reply(32'h0, 1'b0);
        wait_new("v1_c3", 6'd3, 32'h0);
        reply(32'h0001_0000, 1'b0);
        check("v1_done", 32'(init_done), 32'd1);
        check("v1_v2", 32'(v2_card), 32'd0);
        check("v1_ccs", 32'(ccs), 32'd0);
        check("v1_rca", 32'(rca), 32'h0000_0001);
        repeat (2) @(negedge clock);

        // Bad CMD8 echo aborts with code 2 and stops issuing commands.
        pulse_start();
        wait_new("echo_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("echo_c8", 6'd8, 32'h0000_01AA);
        reply(32'h0000_01AB, 1'b0);
        check("echo_err", 32'(init_error), 32'd1);
        check("echo_code", 32'(error_code), 32'd2);
        check("echo_busy", 32'(busy), 32'd0);
        check("echo_done", 32'(init_done), 32'd0);
        @(negedge clock);
        n_snap = n_new;
        repeat (20) @(negedge clock);
        check("echo_quiet", 32'(n_new), 32'(n_snap));

        // Card never ready: exactly RETRIES ACMD41 issues, then code 3.
        idx_log.delete();
        pulse_start();
        check("rty_err_clr", 32'(init_error), 32'd0);
        check("rty_code_clr", 32'(error_code), 32'd0);
        wait_new("rty_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("rty_c8", 6'd8, 32'h0000_01AA);
        reply(32'h0000_01AA, 1'b0);
        for (int k = 0; k < RETRIES; k++) begin
            wait_new("rty_c55", 6'd55, 32'h0);
            if (k > 0) check("rty_gap", 32'(t_new - t_done), 32'(GAP));
            reply(32'h0000_0120, 1'b0);
            wait_new("rty_a41", 6'd41, 32'h40FF_8000);
            reply(32'h00FF_8000, 1'b0);
        end
        check("rty_err", 32'(init_error), 32'd1);
        check("rty_code", 32'(error_code), 32'd3);
        repeat (GAP + 10) @(negedge clock);
        n41 = 0;
        foreach (idx_log[i]) if (idx_log[i] == 6'd41) n41++;
        check("rty_n41", 32'(n41), 32'(RETRIES));

        // CMD2 never completes: local wait limit expires, code 4.
        pulse_start();
        wait_new("wl_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("wl_c8", 6'd8, 32'h0000_01AA);
        reply(32'h0000_01AA, 1'b0);
        wait_new("wl_c55", 6'd55, 32'h0);
        reply(32'h0000_0120, 1'b0);
        wait_new("wl_a41", 6'd41, 32'h40FF_8000);
        reply(32'hC0FF_8000, 1'b0);
        wait_new("wl_c2", 6'd2, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (init_error) begin
                seen = 1'b1;
                break;
            end
        end
        check("wl_seen", 32'(seen), 32'd1);
        check("wl_time", 32'(cyc - (t_new + 1)), 32'(WLIM));
        check("wl_code", 32'(error_code), 32'd4);

        // Reset in the middle of a retry gap clears everything.
        pulse_start();
        wait_new("rg_c0", 6'd0, 32'h0);
        reply(32'h0, 1'b1);
        wait_new("rg_c8", 6'd8, 32'h0000_01AA);
        reply(32'h0000_01AA, 1'b0);
        wait_new("rg_c55", 6'd55, 32'h0);
        reply(32'h0000_0120, 1'b0);
        wait_new("rg_a41", 6'd41, 32'h40FF_8000);
        reply(32'h00FF_8000, 1'b0);
        repeat (3) @(negedge clock);
        check("rg_busy_pre", 32'(busy), 32'd1);
        check("rg_v2_pre", 32'(v2_card), 32'd1);
        reset = 1'b1;
        #1;
        check_cleared("rg_rst");
        @(negedge clock);
        reset = 1'b0;
        n_snap = n_new;
        repeat (GAP + 20) @(negedge clock);
        check("rg_quiet", 32'(n_new), 32'(n_snap));
        pulse_start();
        wait_new("rg_restart", 6'd0, 32'h0);
        @(negedge clock);
        n_snap = n_new;
        pulse_start();
        repeat (8) @(negedge clock);
        check("rg_start_busy", 32'(n_new), 32'(n_snap));
        reply(32'h0, 1'b1);
        wait_new("rg_next", 6'd8, 32'h0000_01AA);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
